// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI requester arbiter: FSM state encodings and
// a ceil(log2) helper used to size pointers and counters.
package spi_arb_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  // Bits needed to hold values 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits++;
      rem = rem >> 1;
    end
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/spi_req_arbiter_rr_picker.sv
// Round-robin picker: first asserted request at or after the pointer,
// wrapping past the top index. Purely combinational.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx
);

  int               sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    sum    = 0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = int'(ptr) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      cand = IDX_W'(sum);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
    if (valid) onehot = NUM_REQ'(1) << idx;
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Shares one SPI master core between NUM_REQ requesters: round-robin grant,
// one word per transaction, timeout abort, and an idle gap between words.
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_cpol,
  input  logic [NUM_REQ-1:0]        req_cpha,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      err,
  output logic                      core_start,
  output logic [DATA_W-1:0]         core_data_wr,
  output logic                      core_polarity,
  output logic                      core_phase,
  input  logic                      core_done,
  input  logic [DATA_W-1:0]         core_data_rd
);

  localparam int IDX_W   = clog2(NUM_REQ);
  localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = clog2(CNT_MAX + 1);

  logic [2:0]         state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   next_ptr;
  logic [CNT_W-1:0]   cnt;
  logic               pick_valid;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic [DATA_W-1:0]  data_arr [NUM_REQ];

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req    (req),
    .ptr    (ptr),
    .valid  (pick_valid),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  assign next_ptr = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  // NOTE: state and registered outputs use non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      win_idx       <= '0;
      cnt           <= '0;
      gnt           <= '0;
      done          <= '0;
      err           <= 1'b0;
      rd_data       <= '0;
      core_start    <= 1'b0;
      core_data_wr  <= '0;
      core_polarity <= 1'b0;
      core_phase    <= 1'b0;
    end else begin
      done       <= '0;
      err        <= 1'b0;
      core_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            win_idx       <= pick_idx;
            gnt           <= pick_onehot;
            core_data_wr  <= data_arr[pick_idx];
            core_polarity <= req_cpol[pick_idx];
            core_phase    <= req_cpha[pick_idx];
            state         <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          core_start <= 1'b1;
          state      <= ST_START;
        end
        ST_START: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A core_done landing on the final timeout cycle still wins.
          if (core_done) begin
            rd_data <= core_data_rd;
            done    <= gnt;
            gnt     <= '0;
            ptr     <= next_ptr;
            cnt     <= '0;
            state   <= ST_GAP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            rd_data <= '0;
            done    <= gnt;
            err     <= 1'b1;
            gnt     <= '0;
            ptr     <= next_ptr;
            cnt     <= '0;
            state   <= ST_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt == CNT_W'(GAP_CYCLES - 1)) state <= ST_IDLE;
          else cnt <= cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed self-checking bench for spi_req_arbiter with a simple core model
// that answers each core_start after a programmable number of cycles.
module tb_spi_req_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_W     = 8;
  localparam int GAP_CYCLES = 4;
  localparam int TIMEOUT    = 1024;

  logic                      clk;
  logic                      reset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_cpol;
  logic [NUM_REQ-1:0]        req_cpha;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         rd_data;
  logic                      err;
  logic                      core_start;
  logic [DATA_W-1:0]         core_data_wr;
  logic                      core_polarity;
  logic                      core_phase;
  logic                      core_done;
  logic [DATA_W-1:0]         core_data_rd;

  logic              model_done;
  logic [DATA_W-1:0] model_rd;
  logic              spur_done;
  logic              core_respond;
  int                core_lat;
  logic [DATA_W-1:0] core_rsp;

  int n_checks;
  int n_fail;

  assign core_done    = model_done | spur_done;
  assign core_data_rd = spur_done ? 8'h55 : model_rd;

  spi_req_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_W     (DATA_W),
    .GAP_CYCLES (GAP_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_data      (req_data),
    .req_cpol      (req_cpol),
    .req_cpha      (req_cpha),
    .gnt           (gnt),
    .done          (done),
    .rd_data       (rd_data),
    .err           (err),
    .core_start    (core_start),
    .core_data_wr  (core_data_wr),
    .core_polarity (core_polarity),
    .core_phase    (core_phase),
    .core_done     (core_done),
    .core_data_rd  (core_data_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: answers core_start after core_lat cycles when enabled.
  initial begin
    model_done = 1'b0;
    model_rd   = '0;
    forever begin
      @(negedge clk);
      if (core_start && core_respond) begin
        repeat (core_lat) @(negedge clk);
        model_rd   = core_rsp;
        model_done = 1'b1;
        @(negedge clk);
        model_done = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input int max_cyc, output int cyc, output logic ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      if (done != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_gnt(input int max_cyc, output logic ok);
    ok = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (gnt != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_start(input int max_cyc, output logic ok);
    ok = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (core_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int   cyc;
    int   n;
    int   starts;
    int   hits;
    logic ok;

    n_checks     = 0;
    n_fail       = 0;
    reset        = 1'b1;
    req          = '0;
    req_data     = '0;
    req_cpol     = '0;
    req_cpha     = '0;
    spur_done    = 1'b0;
    core_respond = 1'b1;
    core_lat     = 2;
    core_rsp     = 8'hAF;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_start", core_start, 0);
    check("rst_wr", core_data_wr, 0);
    check("rst_pol", core_polarity, 0);
    check("rst_pha", core_phase, 0);
    check("rst_rd", rd_data, 0);
    reset = 1'b0;

    // Spurious core_done while idle is ignored
    @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    check("spur_done", done, 0);
    check("spur_rd", rd_data, 0);
    @(negedge clk);
    check("spur_gnt", gnt, 0);

    // Single request: grant at t+1, start at t+2, read word returned
    req_data[15:8] = 8'hCA;
    req            = 4'b0010;
    @(negedge clk);
    check("one_gnt", gnt, 4'b0010);
    check("one_wr", core_data_wr, 8'hCA);
    check("one_pol", core_polarity, 0);
    check("one_start_t1", core_start, 0);
    @(negedge clk);
    check("one_start_t2", core_start, 1);
    @(negedge clk);
    check("one_start_t3", core_start, 0);
    wait_done(50, cyc, ok);
    check("one_seen", ok, 1);
    check("one_done", done, 4'b0010);
    check("one_err", err, 0);
    check("one_rd", rd_data, 8'hAF);
    check("one_gnt_clr", gnt, 0);
    req = '0;
    @(negedge clk);
    check("one_pulse", done, 0);
    repeat (GAP_CYCLES + 2) @(negedge clk);

    // All four requesting from pointer 0: order 0,1,2,3,0
    do_reset();
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    core_rsp = 8'h10;
    req      = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_done(100, cyc, ok);
      check("rr_seen", ok, 1);
      check("rr_done", done, 32'(1) << (i % 4));
      check("rr_rd", rd_data, 32'h10 + i);
      check("rr_wr", core_data_wr, 32'hA0 + (i % 4));
      check("rr_err", err, 0);
      core_rsp = 8'(8'h11 + i);
    end
    req = '0;
    repeat (GAP_CYCLES + 2) @(negedge clk);

    // Mode switch 3 -> 0: config holds through the gap, no start during gap
    req_data[31:24] = 8'h3C;
    req_data[7:0]   = 8'hC0;
    req_cpol        = 4'b1000;
    req_cpha        = 4'b1001;
    core_rsp        = 8'h66;
    req             = 4'b1000;
    wait_gnt(20, ok);
    check("mode_gnt3_seen", ok, 1);
    check("mode_gnt3", gnt, 4'b1000);
    check("mode_pol3", core_polarity, 1);
    req = 4'b1001;
    wait_done(50, cyc, ok);
    check("mode_done3", done, 4'b1000);
    req = 4'b0001;
    check("mode_pol_hold", core_polarity, 1);
    n      = 0;
    starts = 0;
    while (core_polarity == 1'b1 && n < 50) begin
      if (core_start) starts++;
      @(negedge clk);
      n++;
    end
    check("mode_gap_len", n, GAP_CYCLES + 1);
    check("mode_gap_starts", starts, 0);
    check("mode_pha0", core_phase, 1);
    check("mode_gnt0", gnt, 4'b0001);
    check("mode_wr0", core_data_wr, 8'hC0);
    wait_done(50, cyc, ok);
    check("mode_done0", done, 4'b0001);
    check("mode_rd0", rd_data, 8'h66);
    req = '0;
    repeat (GAP_CYCLES + 2) @(negedge clk);

    // Timeout on requester 2 while 3 waits; then 3 is served normally
    core_respond = 1'b0;
    req_cpol     = '0;
    req_cpha     = '0;
    req          = 4'b0100;
    wait_start(20, ok);
    check("to_start_seen", ok, 1);
    req = 4'b1100;
    n   = 0;
    while (done == '0 && n < TIMEOUT + 20) begin
      @(negedge clk);
      n++;
    end
    check("to_latency", n, TIMEOUT + 1);
    check("to_done", done, 4'b0100);
    check("to_err", err, 1);
    check("to_rd", rd_data, 0);
    req          = 4'b1000;
    core_respond = 1'b1;
    core_rsp     = 8'h77;
    wait_done(50, cyc, ok);
    check("to_next_done", done, 4'b1000);
    check("to_next_err", err, 0);
    check("to_next_rd", rd_data, 8'h77);
    req = '0;
    repeat (GAP_CYCLES + 2) @(negedge clk);

    // core_done on the very last WAIT cycle is a normal completion
    core_lat = TIMEOUT;
    core_rsp = 8'h5A;
    req      = 4'b0001;
    wait_start(20, ok);
    n = 0;
    while (done == '0 && n < TIMEOUT + 20) begin
      @(negedge clk);
      n++;
    end
    check("edge_latency", n, TIMEOUT + 1);
    check("edge_done", done, 4'b0001);
    check("edge_err", err, 0);
    check("edge_rd", rd_data, 8'h5A);
    req      = '0;
    core_lat = 2;
    repeat (GAP_CYCLES + 2) @(negedge clk);

    // Reset during WAIT: outputs cleared, the late core_done is ignored
    req_data[15:8] = 8'h11;
    req_cpol       = 4'b0010;
    core_lat       = 20;
    core_rsp       = 8'h99;
    req            = 4'b0010;
    wait_start(20, ok);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rw_gnt", gnt, 0);
    check("rw_done", done, 0);
    check("rw_wr", core_data_wr, 0);
    check("rw_pol", core_polarity, 0);
    check("rw_rd", rd_data, 0);
    reset = 1'b0;
    req   = '0;
    hits  = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done != '0 || gnt != '0) hits++;
    end
    check("rw_no_done", hits, 0);
    check("rw_rd_after", rd_data, 0);

    // Requester 2 drops req right after grant: done still pulses
    core_lat       = 3;
    core_rsp       = 8'h42;
    req_data[23:16] = 8'h2D;
    req            = 4'b0100;
    wait_gnt(20, ok);
    check("drop_gnt", gnt, 4'b0100);
    req = '0;
    wait_done(50, cyc, ok);
    check("drop_seen", ok, 1);
    check("drop_done", done, 4'b0100);
    check("drop_rd", rd_data, 8'h42);
    repeat (GAP_CYCLES + 2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
